// File: rtl/mod_pkg.sv
// Shared types and defaults for the shared divide/modulus scheduler.
package mod_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned NREQ_DEF  = 2;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFin
  } state_e;

endpackage

// File: rtl/mod_iter_core.sv
// Restoring divider: one quotient bit per cycle, MSB first, fixed WIDTH-cycle latency.
module mod_iter_core
  import mod_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  // done flags the cycle whose step produces the final result; quot/rem carry
  // that step's values so the caller can register them on the same edge.
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);

  localparam int unsigned   CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  logic             running_q, running_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  // Dividend shifts out MSB first while quotient bits shift in at the LSB.
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH:0]   rem_q, rem_d;

  logic [WIDTH+1:0] diff;
  logic [WIDTH:0]   rem_step;
  logic [WIDTH-1:0] quot_step;

  // One restoring step: shift in next dividend bit, trial-subtract divisor.
  always_comb begin
    diff = {rem_q, dvd_q[WIDTH-1]} - {2'b00, dsr_q};
    if (diff[WIDTH+1]) begin
      rem_step  = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
      quot_step = {dvd_q[WIDTH-2:0], 1'b0};
    end else begin
      rem_step  = diff[WIDTH:0];
      quot_step = {dvd_q[WIDTH-2:0], 1'b1};
    end
  end

  // Next-state: load on start, otherwise iterate while running.
  always_comb begin
    running_d = running_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    dsr_d     = dsr_q;
    rem_d     = rem_q;
    if (start) begin
      running_d = 1'b1;
      cnt_d     = '0;
      dvd_d     = dividend;
      dsr_d     = divisor;
      rem_d     = '0;
    end else if (running_q) begin
      dvd_d = quot_step;
      rem_d = rem_step;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CntLast) running_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      running_q <= 1'b0;
      cnt_q     <= '0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      rem_q     <= '0;
    end else begin
      running_q <= running_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      dsr_q     <= dsr_d;
      rem_q     <= rem_d;
    end
  end

  assign done = running_q && (cnt_q == CntLast);
  assign quot = quot_step;
  assign rem  = rem_step[WIDTH-1:0];

endmodule

// File: rtl/mod_scheduler.sv
// Round-robin arbiter sharing one iterative divider between NREQ requesters.
module mod_scheduler
  import mod_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned NREQ  = NREQ_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] num,
  input  logic [NREQ*WIDTH-1:0] divider,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic [WIDTH-1:0]      quot,
  output logic [WIDTH-1:0]      rem,
  output logic                  div_zero,
  output logic                  busy
);

  localparam int unsigned IdxW = $clog2(NREQ);

  state_e           state_q, state_d;
  logic [IdxW-1:0]  rr_q, rr_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dz_q, dz_d;

  logic             found;
  logic [IdxW-1:0]  sel;
  logic [IdxW-1:0]  rr_next;
  logic [NREQ-1:0]  sel_oh;
  logic [WIDTH-1:0] sel_num, sel_div;

  logic             core_start, core_done;
  logic [WIDTH-1:0] core_quot, core_rem;

  // Arbiter: first asserted req searching upward from rr pointer, wrapping.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int off = 0; off < int'(NREQ); off++) begin
      for (int k = 0; k < int'(NREQ); k++) begin
        if (!found && req[k] && (((int'(rr_q) + off) % int'(NREQ)) == k)) begin
          found = 1'b1;
          sel   = IdxW'(k);
        end
      end
    end
  end

  // Operand mux and one-hot of the selected requester.
  always_comb begin
    sel_num = '0;
    sel_div = '0;
    sel_oh  = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      if (sel == IdxW'(k)) begin
        sel_num   = num[k*WIDTH +: WIDTH];
        sel_div   = divider[k*WIDTH +: WIDTH];
        sel_oh[k] = 1'b1;
      end
    end
    rr_next = (sel == IdxW'(NREQ - 1)) ? '0 : sel + 1'b1;
  end

  // FSM next-state and output-register updates.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    grant_d    = grant_q;
    done_d     = '0;
    quot_d     = quot_q;
    rem_d      = rem_q;
    dz_d       = dz_q;
    core_start = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          grant_d = sel_oh;
          rr_d    = rr_next;
          if (sel_div == '0) begin
            // Divide by zero skips the engine and finishes next cycle.
            state_d = StFin;
            done_d  = sel_oh;
            quot_d  = '1;
            rem_d   = sel_num;
            dz_d    = 1'b1;
          end else begin
            state_d    = StRun;
            core_start = 1'b1;
          end
        end
      end
      StRun: begin
        if (core_done) begin
          state_d = StFin;
          done_d  = grant_q;
          quot_d  = core_quot;
          rem_d   = core_rem;
          dz_d    = 1'b0;
        end
      end
      StFin: begin
        state_d = StIdle;
        grant_d = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      rr_q    <= '0;
      grant_q <= '0;
      done_q  <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  mod_iter_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .start   (core_start),
    .dividend(sel_num),
    .divisor (sel_div),
    .done    (core_done),
    .quot    (core_quot),
    .rem     (core_rem)
  );

  assign grant    = grant_q;
  assign done     = done_q;
  assign quot     = quot_q;
  assign rem      = rem_q;
  assign div_zero = dz_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_mod_scheduler.sv
// Self-checking bench for mod_scheduler: vector table, hand sequences, random vs model.
module tb_mod_scheduler;

  localparam int unsigned W = 16;
  localparam int unsigned N = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] num, divider;
  logic [N-1:0]   grant, done;
  logic [W-1:0]   quot, rem;
  logic           div_zero, busy;

  logic [W-1:0] num_v [N];
  logic [W-1:0] div_v [N];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rr_m     = 0;

  typedef struct {
    logic [N-1:0] req;
    logic [W-1:0] n0, d0, n1, d1;
    int           idx;
    logic [W-1:0] q, r;
    logic         dz;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  always_comb begin
    num     = '0;
    divider = '0;
    for (int k = 0; k < int'(N); k++) begin
      num[k*W +: W]     = num_v[k];
      divider[k*W +: W] = div_v[k];
    end
  end

  mod_scheduler #(
    .WIDTH(W),
    .NREQ (N)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .num     (num),
    .divider (divider),
    .grant   (grant),
    .done    (done),
    .quot    (quot),
    .rem     (rem),
    .div_zero(div_zero),
    .busy    (busy)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: unsigned divide with the divide-by-zero convention.
  task automatic model(input logic [W-1:0] n, input logic [W-1:0] d,
                       output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
    if (d == '0) begin
      q  = '1;
      r  = n;
      dz = 1'b1;
    end else begin
      q  = n / d;
      r  = n % d;
      dz = 1'b0;
    end
  endtask

  // Reference arbitration: first pending requester at or after the rotation point.
  function automatic int pick(input logic [N-1:0] rq, input int ptr);
    for (int off = 0; off < int'(N); off++) begin
      if (rq[(ptr + off) % int'(N)]) return (ptr + off) % int'(N);
    end
    return -1;
  endfunction

  function automatic vec_t mk(input logic [N-1:0] rq, input int n0, input int d0,
                              input int n1, input int d1, input int idx,
                              input int q, input int r, input logic dz);
    vec_t v;
    v.req = rq;
    v.n0  = W'(n0);
    v.d0  = W'(d0);
    v.n1  = W'(n1);
    v.d1  = W'(d1);
    v.idx = idx;
    v.q   = W'(q);
    v.r   = W'(r);
    v.dz  = dz;
    return v;
  endfunction

  function automatic logic [W-1:0] rand_div();
    int unsigned mode;
    mode = $urandom_range(0, 7);
    if (mode == 0) return '0;
    if (mode <= 2) return W'($urandom_range(1, 15));
    if (mode == 3) return '1;
    return W'($urandom);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick();
    tick();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quot", 32'(quot), 32'd0);
    check("rst_rem", 32'(rem), 32'd0);
    check("rst_dz", 32'(div_zero), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst  = 1'b0;
    rr_m = 0;
  endtask

  // One full operation starting from an IDLE cycle in which req is already driven.
  task automatic serve(input int exp_idx, input bit hold, input bit scramble,
                       output logic [W-1:0] oq, output logic [W-1:0] orr,
                       output logic odz, output int dcyc);
    int           waitc, lat;
    logic [W-1:0] n, d, eq, er;
    logic         edz;
    logic [N-1:0] oh;
    oh = '0;
    oh[exp_idx] = 1'b1;
    tick();
    waitc = 1;
    while (grant == '0 && waitc < 4) begin
      tick();
      waitc++;
    end
    check("grant_wait", 32'(waitc), 32'd1);
    check("grant_idx", 32'(grant), 32'(oh));
    check("busy_run", 32'(busy), 32'd1);
    n = num_v[exp_idx];
    d = div_v[exp_idx];
    model(n, d, eq, er, edz);
    rr_m = (exp_idx + 1) % int'(N);
    if (!hold) req[exp_idx] = 1'b0;
    if (scramble) begin
      num_v[exp_idx] = W'($urandom);
      div_v[exp_idx] = W'($urandom);
    end
    lat = 0;
    while (done == '0 && lat < int'(W) + 4) begin
      tick();
      lat++;
    end
    dcyc = cyc;
    check("done_lat", 32'(lat), (d == '0) ? 32'd0 : 32'(W));
    check("done_idx", 32'(done), 32'(oh));
    check("grant_fin", 32'(grant), 32'(oh));
    check("quot", 32'(quot), 32'(eq));
    check("rem", 32'(rem), 32'(er));
    check("div_zero", 32'(div_zero), 32'(edz));
    oq  = quot;
    orr = rem;
    odz = div_zero;
    tick();
    check("idle_done", 32'(done), 32'd0);
    check("idle_grant", 32'(grant), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [W-1:0] q, r;
    logic         dz;
    int           dc, idx;

    rst = 1'b1;
    req = '0;
    for (int k = 0; k < int'(N); k++) begin
      num_v[k] = '0;
      div_v[k] = '0;
    end

    vecs[0] = mk(2'b01, 100, 7, 0, 0, 0, 14, 2, 1'b0);
    vecs[1] = mk(2'b10, 0, 0, 'h1234, 0, 1, 'hFFFF, 'h1234, 1'b1);
    vecs[2] = mk(2'b01, 'hFFFF, 1, 0, 0, 0, 'hFFFF, 0, 1'b0);
    vecs[3] = mk(2'b10, 0, 0, 5, 9, 1, 0, 5, 1'b0);
    vecs[4] = mk(2'b01, 0, 3, 0, 0, 0, 0, 0, 1'b0);
    vecs[5] = mk(2'b10, 0, 0, 'hFFFF, 'hFFFF, 1, 1, 0, 1'b0);
    vecs[6] = mk(2'b01, 'h8000, 'hFF, 0, 0, 0, 'h80, 'h80, 1'b0);
    vecs[7] = mk(2'b10, 0, 0, 0, 0, 1, 'hFFFF, 0, 1'b1);

    do_reset();

    // Table vectors; odd entries also scramble operands right after grant.
    for (int i = 0; i < 8; i++) begin
      num_v[0] = vecs[i].n0;
      div_v[0] = vecs[i].d0;
      num_v[1] = vecs[i].n1;
      div_v[1] = vecs[i].d1;
      req      = vecs[i].req;
      serve(vecs[i].idx, 1'b0, (i % 2) == 1, q, r, dz, dc);
      check("tbl_quot", 32'(q), 32'(vecs[i].q));
      check("tbl_rem", 32'(r), 32'(vecs[i].r));
      check("tbl_dz", 32'(dz), 32'(vecs[i].dz));
    end

    // Simultaneous requests after reset: requester 0 first, then 1.
    do_reset();
    num_v[0] = 16'd47;
    div_v[0] = 16'd5;
    num_v[1] = 16'd1000;
    div_v[1] = 16'd33;
    req      = 2'b11;
    cyc      = 0;
    serve(0, 1'b0, 1'b0, q, r, dz, dc);
    check("sim0_cyc", 32'(dc), 32'd17);
    check("sim0_q", 32'(q), 32'd9);
    check("sim0_r", 32'(r), 32'd2);
    serve(1, 1'b0, 1'b0, q, r, dz, dc);
    check("sim1_cyc", 32'(dc), 32'd35);
    check("sim1_q", 32'(q), 32'd30);
    check("sim1_r", 32'(r), 32'd10);

    // Both requests held: strict alternation.
    do_reset();
    num_v[0] = 16'd301;
    div_v[0] = 16'd3;
    num_v[1] = 16'd517;
    div_v[1] = 16'd4;
    req      = 2'b11;
    for (int it = 0; it < 6; it++) begin
      idx = pick(req, rr_m);
      check("rr_seq", 32'(idx), 32'(it % 2));
      serve(idx, 1'b1, 1'b0, q, r, dz, dc);
    end
    req = '0;

    // Reset in the middle of a run aborts without a done pulse.
    num_v[0] = 16'd1000;
    div_v[0] = 16'd7;
    req      = 2'b01;
    tick();
    check("abort_grant", 32'(grant), 32'd1);
    repeat (7) tick();
    check("abort_prebusy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    check("abort_grant0", 32'(grant), 32'd0);
    check("abort_done0", 32'(done), 32'd0);
    check("abort_busy0", 32'(busy), 32'd0);
    check("abort_quot0", 32'(quot), 32'd0);
    check("abort_rem0", 32'(rem), 32'd0);
    check("abort_dz0", 32'(div_zero), 32'd0);
    rst  = 1'b0;
    rr_m = 0;
    serve(0, 1'b0, 1'b0, q, r, dz, dc);
    check("abort_retry_q", 32'(q), 32'd142);
    check("abort_retry_r", 32'(r), 32'd6);

    // Random traffic against the reference model.
    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < int'(N); k++) begin
        if (!req[k] && $urandom_range(0, 1) == 1) begin
          num_v[k] = W'($urandom);
          div_v[k] = rand_div();
          req[k]   = 1'b1;
        end
      end
      if (req == '0) begin
        idx        = int'($urandom_range(0, N - 1));
        num_v[idx] = W'($urandom);
        div_v[idx] = rand_div();
        req[idx]   = 1'b1;
      end
      idx = pick(req, rr_m);
      serve(idx, 1'b0, $urandom_range(0, 1) == 1, q, r, dz, dc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
